// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word read to
// instruction memory, and holds the returned word for decode until it is consumed or flushed.
module pc_fetch_unit #(
  parameter int                  DATA_WID = 32,
  parameter logic [DATA_WID-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [DATA_WID-1:0] flush_pc,
  input  logic [DATA_WID-1:0] next_pc,
  input  logic                if_ready,
  output logic                if_valid,
  output logic [DATA_WID-1:0] if_pc,
  output logic [31:0]         if_inst,
  output logic                if_fault,
  output logic                imem_req,
  output logic [DATA_WID-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                fault_q, fault_d;

  logic pc_misaligned;
  logic req_accepted;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign req_accepted  = imem_req & imem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Flush is tested first in every state so a redirect always wins.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;

    unique case (state_q)
      BOOT: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        state_d = REQ;
      end

      REQ: begin
        if (flush) begin
          pc_d = flush_pc;
          // An accepted request still owes us a response, so it must be absorbed.
          state_d = req_accepted ? DRAIN : REQ;
        end else if (pc_misaligned) begin
          inst_d  = NOP_INST;
          fault_d = 1'b1;
          state_d = HOLD;
        end else if (req_accepted) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          inst_d  = imem_rdata;
          fault_d = 1'b0;
          state_d = HOLD;
        end
      end

      DRAIN: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end

      HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = REQ;
        end else if (if_ready && !stall) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign if_valid  = (state_q == HOLD);
  assign if_pc     = pc_q;
  assign if_inst   = inst_q;
  assign if_fault  = fault_q;
  assign imem_req  = (state_q == REQ) && !pc_misaligned;
  assign imem_addr = pc_q;

  // Read data may only arrive while a read is outstanding (WAIT or DRAIN).
  a_rvalid_protocol: assert property (
    @(posedge clk) disable iff (!rst)
      !(imem_rvalid && (state_q == BOOT || state_q == REQ || state_q == HOLD))
  );

endmodule
